// File: rtl/calc_port_arbiter_if.sv
// Port/ALU bundle for calc_port_arbiter: four requester ports plus the shared ALU handshake.
interface calc_port_arbiter_if #(
  parameter int NPORTS = 4,
  parameter int DW     = 32
);
  logic [4*NPORTS-1:0]  req_cmd_in;
  logic [DW*NPORTS-1:0] req_data_in;
  logic [2*NPORTS-1:0]  out_resp;
  logic [DW*NPORTS-1:0] out_data;
  logic [NPORTS-1:0]    port_busy;
  logic                 alu_start;
  logic [3:0]           alu_op;
  logic [DW-1:0]        alu_a;
  logic [DW-1:0]        alu_b;
  logic                 alu_done;
  logic [DW-1:0]        alu_result;
  logic                 alu_err;

  modport slave (
    input  req_cmd_in, req_data_in, alu_done, alu_result, alu_err,
    output out_resp, out_data, port_busy, alu_start, alu_op, alu_a, alu_b
  );

  modport master (
    output req_cmd_in, req_data_in, alu_done, alu_result, alu_err,
    input  out_resp, out_data, port_busy, alu_start, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/calc_port_arbiter.sv
// Round-robin scheduler of four calculator ports onto one shared ALU, one operation in flight.
// Optional ALU watchdog enabled by defining CALC_ARB_TIMEOUT_EN.
module calc_port_arbiter #(
  parameter int NPORTS         = 4,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                c_clk,
  input logic                reset,
  calc_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(NPORTS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d, gnt_q, gnt_d;
  logic [NPORTS-1:0]    cap_q, cap_d, busy_q, busy_d;
  logic [3:0]           cmd_q [NPORTS];
  logic [3:0]           cmd_d [NPORTS];
  logic [DW-1:0]        opa_q [NPORTS];
  logic [DW-1:0]        opa_d [NPORTS];
  logic [DW-1:0]        opb_q [NPORTS];
  logic [DW-1:0]        opb_d [NPORTS];
  logic [2*NPORTS-1:0]  resp_q, resp_d;
  logic [DW*NPORTS-1:0] rdata_q, rdata_d;
  logic                 start_q, start_d;
  logic [3:0]           op_q, op_d;
  logic [DW-1:0]        a_q, a_d, b_q, b_d;
  logic [PW-1:0]        pick_s;
  logic                 found_s;
  logic                 tmo_hit_s;

  function automatic logic cmd_valid(input logic [3:0] c);
    case (c)
      4'd1, 4'd2, 4'd5, 4'd6: cmd_valid = 1'b1;
      default:                cmd_valid = 1'b0;
    endcase
  endfunction

`ifdef CALC_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    if (state_q == WAIT) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = '0;
    end
    tmo_hit_s = (state_q == WAIT) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_tmo_s;
  assign unused_tmo_s = (TIMEOUT_CYCLES > 0);
  assign tmo_hit_s    = 1'b0;
`endif

  // First pending port at or after the round-robin pointer (wraps mod NPORTS).
  always_comb begin
    found_s = 1'b0;
    pick_s  = ptr_q;
    for (int k = 0; k < NPORTS; k++) begin
      if (!found_s && busy_q[ptr_q + PW'(k)]) begin
        found_s = 1'b1;
        pick_s  = ptr_q + PW'(k);
      end else begin
        found_s = found_s;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cap_d   = cap_q;
    busy_d  = busy_q;
    cmd_d   = cmd_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    resp_d  = '0;
    rdata_d = '0;
    start_d = 1'b0;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;

    // Busy drops at the response edge, so a command driven during RESP is taken.
    for (int n = 0; n < NPORTS; n++) begin
      if ((state_q == RESP) && (gnt_q == PW'(n))) begin
        busy_d[n] = 1'b0;
      end else begin
        busy_d[n] = busy_q[n];
      end
      if (cap_q[n]) begin
        opb_d[n]  = bus.req_data_in[DW*n +: DW];
        cap_d[n]  = 1'b0;
        busy_d[n] = 1'b1;
      end else if (!busy_d[n] && (bus.req_cmd_in[4*n +: 4] != 4'd0)) begin
        cmd_d[n] = bus.req_cmd_in[4*n +: 4];
        opa_d[n] = bus.req_data_in[DW*n +: DW];
        cap_d[n] = 1'b1;
      end else begin
        cap_d[n] = cap_q[n];
      end
    end

    case (state_q)
      IDLE: begin
        if (found_s) begin
          gnt_d = pick_s;
          ptr_d = pick_s + PW'(1);
          if (cmd_valid(cmd_q[pick_s])) begin
            start_d = 1'b1;
            op_d    = cmd_q[pick_s];
            a_d     = opa_q[pick_s];
            b_d     = opb_q[pick_s];
            state_d = ISSUE;
          end else begin
            resp_d[{pick_s, 1'b0} +: 2] = 2'd2;
            state_d                     = RESP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.alu_done) begin
          state_d = RESP;
          if (bus.alu_err) begin
            resp_d[{gnt_q, 1'b0} +: 2] = 2'd2;
          end else begin
            resp_d[{gnt_q, 1'b0} +: 2]        = 2'd1;
            rdata_d[int'(gnt_q)*DW +: DW]     = bus.alu_result;
          end
        end else if (tmo_hit_s) begin
          state_d                    = RESP;
          resp_d[{gnt_q, 1'b0} +: 2] = 2'd3;
        end else begin
          state_d = WAIT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cap_q   <= '0;
      busy_q  <= '0;
      cmd_q   <= '{default: 4'd0};
      opa_q   <= '{default: '0};
      opb_q   <= '{default: '0};
      resp_q  <= '0;
      rdata_q <= '0;
      start_q <= 1'b0;
      op_q    <= 4'd0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cap_q   <= cap_d;
      busy_q  <= busy_d;
      cmd_q   <= cmd_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      start_q <= start_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign bus.out_resp  = resp_q;
  assign bus.out_data  = rdata_q;
  assign bus.port_busy = busy_q;
  assign bus.alu_start = start_q;
  assign bus.alu_op    = op_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
endmodule

// File: doc/calc_port_arbiter.md
# calc_port_arbiter

Request scheduler for the calculator's shared ALU. It accepts two-cycle command transfers from four requester ports, holds one pending command per port, and grants the ALU round-robin. It sequences one ALU operation at a time and routes each one-cycle response back to the port that issued the command. It sits between the four calculator ports and the add/sub/shift ALU, and is clocked and reset by the testbench clock/reset generator.

## Interface
- NPORTS, 4, number of requester ports (fixed at 4 for this release)
- DW, 32, operand/result width
- TIMEOUT_CYCLES, 64, ALU watchdog limit (used only with CALC_ARB_TIMEOUT_EN)

- c_clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_cmd_in  in  4*NPORTS  per-port command; port n uses bits [4n+3:4n]
- req_data_in  in  DW*NPORTS  per-port data: operand1 in the command cycle, operand2 in the next cycle
- out_resp  out  2*NPORTS  per-port response: 0 none, 1 success, 2 invalid/overflow, 3 internal error
- out_data  out  DW*NPORTS  per-port result, valid only while that port's out_resp≠0
- port_busy  out  NPORTS  1 while the port has a captured, unanswered command
- alu_start  out  1  one-cycle ALU launch strobe
- alu_op  out  4  command code, held from alu_start until alu_done
- alu_a, alu_b  out  DW  operands, held from alu_start until alu_done
- alu_done  in  1  ALU completion strobe
- alu_result  in  DW  ALU result, sampled with alu_done
- alu_err  in  1  ALU overflow/underflow flag, sampled with alu_done

## Operation
- Valid commands: 1 add, 2 sub, 5 shift-left, 6 shift-right. 0 is a no-op. All other codes are invalid.
- Capture: when a non-busy port drives cmd≠0 in cycle t, the block latches cmd and operand1. In t+1 it latches operand2 and ignores cmd. port_busy rises after the t+1 edge.
- Commands on a busy port are ignored and get no response. An invalid code is still captured and is answered with resp 2.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any port is pending, grant the first pending port at or after the RR pointer. The pointer then moves to grantee+1 (mod 4). Valid command → ISSUE. Invalid command → RESP with resp 2 and data 0.
  - ISSUE: alu_start=1 for exactly one cycle, operands driven → WAIT.
  - WAIT: on alu_done → RESP. Response is 1 with data=alu_result when alu_err=0, or 2 with data 0 when alu_err=1.
  - RESP: drive the grantee's out_resp/out_data for one cycle, clear its port_busy → IDLE.
- alu_done outside WAIT is ignored.
- Non-grantee out_resp stays 0 at all times.
- A port may issue a new command in the same cycle its response is driven. The block captures it because busy clears at that edge.

## Timing
- Reset values: out_resp 0, out_data 0, port_busy 0, alu_start 0, alu_op 0, alu_a 0, alu_b 0; FSM in IDLE; RR pointer at port 0; pending flags cleared.
- Reset asserted mid-operation aborts the operation. The pending command is lost, no response is emitted, and any later alu_done is ignored.
- Best-case latency, valid command issued at t on an idle block: grant t+2, alu_start t+3, alu_done t+4 (earliest), out_resp t+5.
- Best-case latency, invalid command: out_resp at t+3.
- Back-to-back grants are separated by at least the RESP cycle, so only one operation is ever in flight.
- If all four ports capture in the same cycle, they are served in RR order starting at the pointer. No port waits more than 3 other operations.

## Configuration
- CALC_ARB_TIMEOUT_EN defined: a counter runs in WAIT. If TIMEOUT_CYCLES cycles pass without alu_done, the FSM goes to RESP with resp 3 and data 0. A late alu_done is ignored.
- CALC_ARB_TIMEOUT_EN not defined: no counter. WAIT holds until alu_done or reset.

## Test plan
- Reset, then port 0 issues add: 0x0000_0005 + 0x0000_0003, ALU done next cycle → port 0 gets resp 1, data 0x8 at t+5. All other resp stay 0.
- Ports 0–3 issue sub in the same cycle → alu_start in port order 0,1,2,3. Each port gets exactly one response. Pointer ends at port 0.
- Port 2 issues cmd 0x3 → resp 2, data 0 at t+3. No alu_start.
- ALU returns alu_err=1 for 0xFFFF_FFFF + 1 → resp 2, data 0.
- Port 1 busy and re-drives cmd 1 → ignored. Exactly one response is produced.
- Reset asserted during WAIT, then alu_done pulsed → no response and all outputs 0. With CALC_ARB_TIMEOUT_EN defined, a withheld alu_done gives resp 3 after 64 WAIT cycles.
